dshot_rx_decoder: RTL and testbench



---
 rtl/dshot_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/dshot_rx_decoder.sv | 266 ++++++++++++++++++++++++++
 tb/tb_dshot_rx_decoder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dshot_pkg.sv
// Shared DShot definitions: frame geometry, command range, receiver FSM
// states and the 4-bit frame checksum shared by the receiver and transmitter.
package dshot_pkg;

    localparam int DSHOT_FRAME_BITS = 16;
    localparam int DSHOT_CMD_MAX    = 47;

    typedef enum logic [2:0] {
        ST_SYNC  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_CHECK = 3'd4
    } dshot_state_e;

    // Checksum over the 12-bit {value, telemetry} word: XOR of its three nibbles.
    function automatic logic [3:0] dshot_crc4(input logic [11:0] w);
        dshot_crc4 = w[3:0] ^ w[7:4] ^ w[11:8];
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, async active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops give the first stage a full cycle to resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/dshot_rx_decoder.sv
// DShot receiver: measures pulse widths on the synchronised line, assembles
// a 16-bit frame MSB first, verifies its checksum and presents an 8-bit
// throttle, telemetry flag and special-command number. Throttle is forced to
// zero when no valid frame has arrived for TIMEOUT_CLKS cycles.
//
// Handshake: there is no back-pressure. frame_valid, crc_err, frame_err and
// cmd_valid are single-cycle pulses; throttle_out, telemetry_req and cmd_out
// are held levels that are stable whenever a pulse is high. At most one of
// frame_valid, crc_err, frame_err is high in any cycle.
module dshot_rx_decoder
    import dshot_pkg::*;
#(
    parameter int CLKS_PER_BIT = 80,
    parameter int GAP_CLKS     = 160,
    parameter int TIMEOUT_CLKS = 4800000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dshot_in,
    output logic [7:0] throttle_out,
    output logic       telemetry_req,
    output logic [5:0] cmd_out,
    output logic       cmd_valid,
    output logic       frame_valid,
    output logic       crc_err,
    output logic       frame_err,
    output logic       link_ok
);

    // Timing thresholds derived from the bit period.
    localparam int HALF_CLKS  = CLKS_PER_BIT / 2;
    localparam int GLITCH_CLK = CLKS_PER_BIT / 8;
    localparam int EARLY_CLKS = (3 * CLKS_PER_BIT) / 4;
    localparam int TRUNC_CLKS = 2 * CLKS_PER_BIT;
    localparam int BT_MAX     = 3 * CLKS_PER_BIT;
    localparam int LC_MAX     = (GAP_CLKS > TRUNC_CLKS) ? GAP_CLKS : TRUNC_CLKS;

    localparam int BT_W  = $clog2(BT_MAX + 1);
    localparam int LC_W  = $clog2(LC_MAX + 1);
    localparam int BC_W  = $clog2(DSHOT_FRAME_BITS + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [BT_W-1:0]  BT_HALF    = BT_W'(HALF_CLKS);
    localparam logic [BT_W-1:0]  BT_GLITCH  = BT_W'(GLITCH_CLK);
    localparam logic [BT_W-1:0]  BT_EARLY   = BT_W'(EARLY_CLKS);
    localparam logic [BT_W-1:0]  BT_BITLAST = BT_W'(CLKS_PER_BIT - 1);
    localparam logic [BT_W-1:0]  BT_SAT     = BT_W'(BT_MAX);
    localparam logic [LC_W-1:0]  LC_GAPLAST = LC_W'(GAP_CLKS - 1);
    localparam logic [LC_W-1:0]  LC_TRLAST  = LC_W'(TRUNC_CLKS - 1);
    localparam logic [BC_W-1:0]  BC_LAST    = BC_W'(DSHOT_FRAME_BITS - 1);
    localparam logic [TMO_W-1:0] TMO_LOAD   = TMO_W'(TIMEOUT_CLKS);
    localparam logic [TMO_W-1:0] TMO_ONE    = TMO_W'(1);
    localparam logic [10:0]      CMD_MAX_V  = 11'(DSHOT_CMD_MAX);

    // Line conditioning: synchroniser, one retiming stage, edge-detect stage.
    logic dshot_sync;
    logic line_q;
    logic prev_q;
    logic rise;
    logic fall;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (dshot_in),
        .q_o   (dshot_sync)
    );

    // Retime the synchronised line and keep its previous value for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            line_q <= dshot_sync;
            prev_q <= line_q;
        end
    end

    assign rise = line_q & ~prev_q;
    assign fall = ~line_q & prev_q;

    // FSM and frame assembly registers. state_q is the observable FSM state.
    dshot_state_e                state_q, state_d;
    logic [BT_W-1:0]             bit_tmr_q, bit_tmr_d;
    logic [LC_W-1:0]             low_cnt_q, low_cnt_d;
    logic [BC_W-1:0]             bit_cnt_q, bit_cnt_d;
    logic [DSHOT_FRAME_BITS-1:0] shift_q, shift_d;
    logic                        frame_err_d;

    // Next-state logic: bit timing decisions and shifting of received bits.
    always_comb begin
        state_d     = state_q;
        bit_tmr_d   = bit_tmr_q;
        low_cnt_d   = low_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        case (state_q)
            ST_SYNC: begin
                if (line_q) begin
                    low_cnt_d = '0;
                end else if (low_cnt_q == LC_GAPLAST) begin
                    low_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    low_cnt_d = low_cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (rise) begin
                    state_d   = ST_HIGH;
                    bit_cnt_d = '0;
                    bit_tmr_d = '0;
                    shift_d   = '0;
                end
            end
            ST_HIGH: begin
                if (fall) begin
                    if (bit_tmr_q < BT_GLITCH) begin
                        frame_err_d = 1'b1;
                        low_cnt_d   = '0;
                        state_d     = ST_SYNC;
                    end else begin
                        shift_d   = {shift_q[DSHOT_FRAME_BITS-2:0], (bit_tmr_q >= BT_HALF)};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        bit_tmr_d = bit_tmr_q + 1'b1;
                        // The falling-edge cycle is the first low clock of the bit.
                        low_cnt_d = LC_W'(1);
                        state_d   = (bit_cnt_q == BC_LAST) ? ST_CHECK : ST_LOW;
                    end
                end else if (bit_tmr_q == BT_BITLAST) begin
                    // Line stuck high for a whole bit period.
                    frame_err_d = 1'b1;
                    low_cnt_d   = '0;
                    state_d     = ST_SYNC;
                end else begin
                    bit_tmr_d = bit_tmr_q + 1'b1;
                end
            end
            ST_LOW: begin
                bit_tmr_d = (bit_tmr_q == BT_SAT) ? bit_tmr_q : bit_tmr_q + 1'b1;
                if (rise) begin
                    if (bit_tmr_q < BT_EARLY) begin
                        frame_err_d = 1'b1;
                        low_cnt_d   = '0;
                        state_d     = ST_SYNC;
                    end else begin
                        bit_tmr_d = '0;
                        state_d   = ST_HIGH;
                    end
                end else if (low_cnt_q == LC_TRLAST) begin
                    // Frame stopped before all bits arrived.
                    frame_err_d = 1'b1;
                    low_cnt_d   = '0;
                    state_d     = ST_SYNC;
                end else begin
                    low_cnt_d = low_cnt_q + 1'b1;
                end
            end
            ST_CHECK: begin
                low_cnt_d = '0;
                state_d   = ST_SYNC;
            end
            default: begin
                low_cnt_d = '0;
                state_d   = ST_SYNC;
            end
        endcase
    end

    // FSM state and frame assembly registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_SYNC;
            bit_tmr_q <= '0;
            low_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_tmr_q <= bit_tmr_d;
            low_cnt_q <= low_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
        end
    end

    // Frame fields as held in the shift register after the last bit.
    logic [10:0] frame_v;
    logic        frame_t;
    logic        is_check;
    logic        crc_ok;

    assign frame_v  = shift_q[15:5];
    assign frame_t  = shift_q[4];
    assign is_check = (state_q == ST_CHECK);
    assign crc_ok   = (dshot_crc4(shift_q[15:4]) == shift_q[3:0]);

    logic [7:0]       throttle_q;
    logic             telemetry_q;
    logic [5:0]       cmd_q;
    logic             cmd_valid_q;
    logic             frame_valid_q;
    logic             crc_err_q;
    logic             frame_err_q;
    logic             link_ok_q;
    logic [TMO_W-1:0] tmo_q;

    // Output update on a checked frame; failsafe countdown otherwise.
    // A valid frame takes priority over an expiring timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            throttle_q    <= '0;
            telemetry_q   <= 1'b0;
            cmd_q         <= '0;
            cmd_valid_q   <= 1'b0;
            frame_valid_q <= 1'b0;
            crc_err_q     <= 1'b0;
            frame_err_q   <= 1'b0;
            link_ok_q     <= 1'b0;
            tmo_q         <= '0;
        end else begin
            cmd_valid_q   <= 1'b0;
            frame_valid_q <= 1'b0;
            crc_err_q     <= 1'b0;
            frame_err_q   <= frame_err_d;
            if (is_check && crc_ok) begin
                frame_valid_q <= 1'b1;
                telemetry_q   <= frame_t;
                tmo_q         <= TMO_LOAD;
                link_ok_q     <= 1'b1;
                if (frame_v <= CMD_MAX_V) begin
                    throttle_q <= '0;
                    if (frame_v != 11'd0) begin
                        cmd_q       <= frame_v[5:0];
                        cmd_valid_q <= 1'b1;
                    end
                end else begin
                    throttle_q <= frame_v[10:3];
                end
            end else begin
                if (is_check) begin
                    crc_err_q <= 1'b1;
                end
                if (tmo_q != '0) begin
                    tmo_q <= tmo_q - 1'b1;
                    if (tmo_q == TMO_ONE) begin
                        link_ok_q  <= 1'b0;
                        throttle_q <= '0;
                    end
                end
            end
        end
    end

    assign throttle_out  = throttle_q;
    assign telemetry_req = telemetry_q;
    assign cmd_out       = cmd_q;
    assign cmd_valid     = cmd_valid_q;
    assign frame_valid   = frame_valid_q;
    assign crc_err       = crc_err_q;
    assign frame_err     = frame_err_q;
    assign link_ok       = link_ok_q;

endmodule

// File: tb/tb_dshot_rx_decoder.sv
// Bench for dshot_rx_decoder: directed and randomised DShot frames, a
// frame-level reference model, and a scoreboard checked by a monitor.
module tb_dshot_rx_decoder;

    localparam int CPB = 80;
    localparam int GAP = 160;
    localparam int TMO = 8000;
    localparam int FAR_PAST = -1000000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dshot_in = 1'b0;
    logic [7:0] throttle_out;
    logic       telemetry_req;
    logic [5:0] cmd_out;
    logic       cmd_valid;
    logic       frame_valid;
    logic       crc_err;
    logic       frame_err;
    logic       link_ok;

    dshot_rx_decoder #(
        .CLKS_PER_BIT (CPB),
        .GAP_CLKS     (GAP),
        .TIMEOUT_CLKS (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .dshot_in      (dshot_in),
        .throttle_out  (throttle_out),
        .telemetry_req (telemetry_req),
        .cmd_out       (cmd_out),
        .cmd_valid     (cmd_valid),
        .frame_valid   (frame_valid),
        .crc_err       (crc_err),
        .frame_err     (frame_err),
        .link_ok       (link_ok)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // kind: 0 = frame accepted, 1 = checksum error, 2 = timing error
    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] at;     // expected observation cycle, 0 = not timed
        logic [7:0]  thr;
        logic        tel;
        logic [5:0]  cmd;
        logic        cmdv;
    } exp_t;
    localparam int EXP_W = $bits(exp_t);
    logic [EXP_W-1:0] exp_q[$];

    int m_thr = 0;
    int m_tel = 0;
    int m_cmd = 0;
    int lv0 = FAR_PAST;   // observation cycle of the previous accepted frame
    int lv1 = FAR_PAST;   // observation cycle of the latest accepted frame

    // Link is up for TMO cycles starting at the cycle an accepted frame appears.
    function automatic bit alive(input int c);
        return (c >= lv1 && c < lv1 + TMO) || (c >= lv0 && c < lv0 + TMO);
    endfunction

    function automatic int crc_of(input int w);
        int c = 0;
        for (int k = 0; k < 3; k++) c = c ^ ((w >> (4 * k)) % 16);
        return c;
    endfunction

    task automatic push_exp(input int kind, input int at, input int thr, input int tel,
                            input int cmd, input int cmdv);
        exp_t e;
        e.kind = 2'(kind);
        e.at   = 32'(at);
        e.thr  = 8'(thr);
        e.tel  = 1'(tel);
        e.cmd  = 6'(cmd);
        e.cmdv = 1'(cmdv);
        exp_q.push_back(e);
    endtask

    // Whole 16-bit frame arrives; its result is observed at cycle pc.
    task automatic expect_frame(input logic [15:0] f, input int pc);
        int v, t, rx, w, cv;
        v  = int'(f) / 32;
        t  = (int'(f) / 16) % 2;
        rx = int'(f) % 16;
        w  = int'(f) / 16;
        cv = 0;
        if (crc_of(w) == rx) begin
            m_tel = t;
            if (v == 0) begin
                m_thr = 0;
            end else if (v <= 47) begin
                m_thr = 0;
                m_cmd = v;
                cv    = 1;
            end else begin
                m_thr = v / 8;
            end
            lv0 = lv1;
            lv1 = pc;
            push_exp(0, pc, m_thr, m_tel, m_cmd, cv);
        end else begin
            push_exp(1, pc, alive(pc) ? m_thr : 0, m_tel, m_cmd, 0);
        end
    endtask

    // ---------------- driver tasks (drive on falling clock edge) ----------------
    // Sends the first n bits of f MSB first; returns the cycle of the last falling edge.
    task automatic send_bits(input logic [15:0] f, input int n, input bit nominal,
                             output int last_fall);
        int hi, per;
        last_fall = 0;
        for (int i = 15; i >= 16 - n; i--) begin
            if (nominal) begin
                hi  = f[i] ? 60 : 30;
                per = 80;
            end else begin
                hi  = f[i] ? int'($urandom_range(48, 70)) : int'($urandom_range(14, 34));
                per = int'($urandom_range(74, 88));
            end
            dshot_in = 1'b1;
            repeat (hi) @(negedge clk);
            dshot_in  = 1'b0;
            last_fall = cyc;
            if (i > 16 - n) repeat (per - hi) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [15:0] f, input bit nominal, input int gap);
        int lf;
        send_bits(f, 16, nominal, lf);
        expect_frame(f, lf + 5);
        repeat (gap) @(negedge clk);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        exp_t e;
        int   kind_act;
        forever begin
            @(posedge clk);
            #1;
            check("link_ok", 64'(link_ok), 64'(alive(cyc)));
            if (!alive(cyc)) check("failsafe_throttle", 64'(throttle_out), 64'd0);
            if (frame_valid || crc_err || frame_err || cmd_valid) begin
                check("single_pulse", 64'(int'(frame_valid) + int'(crc_err) + int'(frame_err)), 64'd1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: actual fv=%0b ce=%0b fe=%0b required none (cycle %0d)",
                             frame_valid, crc_err, frame_err, cyc);
                end else begin
                    e = exp_t'(exp_q.pop_front());
                    kind_act = frame_valid ? 0 : (crc_err ? 1 : 2);
                    check("pulse_kind", 64'(kind_act), 64'(e.kind));
                    if (e.at != 0) check("pulse_cycle", 64'(cyc), 64'(e.at));
                    check("throttle", 64'(throttle_out), 64'(e.thr));
                    check("telemetry", 64'(telemetry_req), 64'(e.tel));
                    check("cmd_out", 64'(cmd_out), 64'(e.cmd));
                    check("cmd_valid", 64'(cmd_valid), 64'(e.cmdv));
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #(10 * 90000);
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        int lf;
        logic [15:0] f;

        // Reset state.
        repeat (10) @(negedge clk);
        check("rst_throttle", 64'(throttle_out), 64'd0);
        check("rst_link_ok", 64'(link_ok), 64'd0);
        check("rst_cmd_out", 64'(cmd_out), 64'd0);
        check("rst_telemetry", 64'(telemetry_req), 64'd0);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);

        // Directed frames.
        send_frame(16'h82C6, 1'b1, 250);   // throttle 130
        send_frame(16'hFFFF, 1'b1, 250);   // v=2047, t=1 -> 255
        send_frame(16'h0000, 1'b1, 250);   // disarm
        send_frame(16'h82C6, 1'b1, 250);
        send_frame(16'h82C7, 1'b1, 250);   // checksum error, 130 held
        send_frame(16'h00BB, 1'b1, 250);   // command 5, t=1

        // 6-clk glitch.
        dshot_in = 1'b1;
        repeat (6) @(negedge clk);
        dshot_in = 1'b0;
        push_exp(2, cyc + 4, alive(cyc + 4) ? m_thr : 0, m_tel, m_cmd, 0);
        repeat (250) @(negedge clk);
        send_frame(16'h82C6, 1'b0, 250);

        // Truncated after 9 bits.
        send_bits(16'hA5A5, 9, 1'b1, lf);
        push_exp(2, 0, alive(lf + 170) ? m_thr : 0, m_tel, m_cmd, 0);
        repeat (400) @(negedge clk);
        send_frame(16'hFFFF, 1'b0, 250);

        // Reset mid-frame.
        send_bits(16'h82C6, 5, 1'b1, lf);
        dshot_in = 1'b1;
        repeat (20) @(negedge clk);
        rst_n    = 1'b0;
        dshot_in = 1'b0;
        m_thr = 0;
        m_tel = 0;
        m_cmd = 0;
        lv0   = FAR_PAST;
        lv1   = FAR_PAST;
        #1;
        check("midrst_throttle", 64'(throttle_out), 64'd0);
        check("midrst_telemetry", 64'(telemetry_req), 64'd0);
        check("midrst_link_ok", 64'(link_ok), 64'd0);
        check("midrst_cmd_out", 64'(cmd_out), 64'd0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (250) @(negedge clk);
        send_frame(16'h82C6, 1'b1, 250);

        // Randomised frames; most carry a correct checksum.
        for (int n = 0; n < 14; n++) begin
            f = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 3) != 0) f[3:0] = 4'(crc_of(int'(f[15:4])));
            send_frame(f, 1'b0, int'($urandom_range(200, 300)));
        end

        // Link loss, then recovery.
        send_frame(16'h82C6, 1'b1, TMO + 50);
        check("tmo_link_ok", 64'(link_ok), 64'd0);
        check("tmo_throttle", 64'(throttle_out), 64'd0);
        check("tmo_telemetry_hold", 64'(telemetry_req), 64'(m_tel));
        check("tmo_cmd_hold", 64'(cmd_out), 64'(m_cmd));
        send_frame(16'h82C6, 1'b0, 250);
        check("recover_link_ok", 64'(link_ok), 64'd1);
        check("recover_throttle", 64'(throttle_out), 64'd130);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
